// File: rtl/rv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_pkg : RV64 decode operation type and encoding constants
// Rev 1.0
// ----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [5:0] {
    OP_ILLEGAL, OP_ADD, OP_ADDW, OP_SUB, OP_SUBW, OP_XOR, OP_OR, OP_AND,
    OP_ADDI, OP_ADDIW, OP_SLTI, OP_ANDI, OP_XORI, OP_ORI, OP_LUI, OP_AUIPC,
    OP_JAL, OP_JALR, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW, OP_REM, OP_REMU,
    OP_REMW, OP_REMUW
  } op_t;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage_if : fetch-side and execute-side handshakes of the decode stage
// Rev 1.0
// ----------------------------------------------------------------------------
interface decode_stage_if import rv_pkg::*; #(
  parameter int XLEN = rv_pkg::XLEN
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  op_t             out_op;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc
  );
endinterface
`default_nettype wire

// File: rtl/rv_decode_comb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_decode_comb : purely combinational RV64 instruction decoder
// Rev 1.0
// ----------------------------------------------------------------------------
module rv_decode_comb import rv_pkg::*; #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic [31:0]     instr_i,
  output op_t             op_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [XLEN-1:0] imm_o
);
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [5:0]      w_funct6;
  logic [XLEN-1:0] w_imm_i, w_imm_u, w_imm_j;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  assign w_funct6 = instr_i[31:26];
  assign w_imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign w_imm_u  = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
  assign w_imm_j  = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    op_o = OP_ILLEGAL;
    case (w_opcode)
      OPC_OP: case ({w_funct7, w_funct3})
        {F7_BASE, F3_ADD}:    op_o = OP_ADD;
        {F7_ALT, F3_ADD}:     op_o = OP_SUB;
        {F7_BASE, F3_XOR}:    op_o = OP_XOR;
        {F7_BASE, F3_OR}:     op_o = OP_OR;
        {F7_BASE, F3_AND}:    op_o = OP_AND;
        {F7_MULDIV, F3_MUL}:  op_o = OP_MUL;
        {F7_MULDIV, F3_DIV}:  op_o = OP_DIV;
        {F7_MULDIV, F3_DIVU}: op_o = OP_DIVU;
        {F7_MULDIV, F3_REM}:  op_o = OP_REM;
        {F7_MULDIV, F3_REMU}: op_o = OP_REMU;
        default: ;
      endcase
      OPC_OP_32: case ({w_funct7, w_funct3})
        {F7_BASE, F3_ADD}:    op_o = OP_ADDW;
        {F7_ALT, F3_ADD}:     op_o = OP_SUBW;
        {F7_MULDIV, F3_MUL}:  op_o = OP_MULW;
        {F7_MULDIV, F3_DIV}:  op_o = OP_DIVW;
        {F7_MULDIV, F3_DIVU}: op_o = OP_DIVUW;
        {F7_MULDIV, F3_REM}:  op_o = OP_REMW;
        {F7_MULDIV, F3_REMU}: op_o = OP_REMUW;
        default: ;
      endcase
      OPC_OP_IMM: case (w_funct3)
        F3_ADD: op_o = OP_ADDI;
        F3_SLT: op_o = OP_SLTI;
        F3_XOR: op_o = OP_XORI;
        F3_OR:  op_o = OP_ORI;
        F3_AND: op_o = OP_ANDI;
        F3_SLL: if (w_funct6 == F7_BASE[6:1]) op_o = OP_SLLI;
        F3_SR: begin
          if (w_funct6 == F7_BASE[6:1])     op_o = OP_SRLI;
          else if (w_funct6 == F7_ALT[6:1]) op_o = OP_SRAI;
        end
        default: ;
      endcase
      // W-form shifts need the full funct7, so shamt[5] set falls out as illegal
      OPC_OP_IMM_32: case (w_funct3)
        F3_ADD: op_o = OP_ADDIW;
        F3_SLL: if (w_funct7 == F7_BASE) op_o = OP_SLLIW;
        F3_SR: begin
          if (w_funct7 == F7_BASE)     op_o = OP_SRLIW;
          else if (w_funct7 == F7_ALT) op_o = OP_SRAIW;
        end
        default: ;
      endcase
      OPC_LUI:   op_o = OP_LUI;
      OPC_AUIPC: op_o = OP_AUIPC;
      OPC_JAL:   op_o = OP_JAL;
      OPC_JALR:  if (w_funct3 == F3_JALR) op_o = OP_JALR;
      default: ;
    endcase
  end

  always_comb begin
    rd_o  = 5'd0;
    rs1_o = 5'd0;
    rs2_o = 5'd0;
    imm_o = {XLEN{1'b0}};
    case (op_o)
      OP_ILLEGAL: ;
      OP_LUI, OP_AUIPC: begin
        rd_o  = instr_i[11:7];
        imm_o = w_imm_u;
      end
      OP_JAL: begin
        rd_o  = instr_i[11:7];
        imm_o = w_imm_j;
      end
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        rd_o  = instr_i[11:7];
        rs1_o = instr_i[19:15];
        imm_o = {{(XLEN-6){1'b0}}, instr_i[25:20]};
      end
      OP_SLLIW, OP_SRLIW, OP_SRAIW: begin
        rd_o  = instr_i[11:7];
        rs1_o = instr_i[19:15];
        imm_o = {{(XLEN-5){1'b0}}, instr_i[24:20]};
      end
      OP_ADDI, OP_ADDIW, OP_SLTI, OP_ANDI, OP_XORI, OP_ORI, OP_JALR: begin
        rd_o  = instr_i[11:7];
        rs1_o = instr_i[19:15];
        imm_o = w_imm_i;
      end
      default: begin
        rd_o  = instr_i[11:7];
        rs1_o = instr_i[19:15];
        rs2_o = instr_i[24:20];
      end
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage : RV64 decoder followed by a 2-entry skid buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module decode_stage import rv_pkg::*; #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);
  typedef struct packed {
    op_t             op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  localparam entry_t ENTRY_RST = '{OP_ILLEGAL, 5'd0, 5'd0, 5'd0,
                                   {XLEN{1'b0}}, {XLEN{1'b0}}};

  op_t             w_op;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm;
  entry_t          w_new;
  logic            w_push, w_pop;

  entry_t          main_q, main_d, skid_q, skid_d;
  logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic            in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rv_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr_i (bus.in_instr),
    .op_o    (w_op),
    .rd_o    (w_rd),
    .rs1_o   (w_rs1),
    .rs2_o   (w_rs2),
    .imm_o   (w_imm)
  );

  assign w_new  = '{w_op, w_rd, w_rs1, w_rs2, w_imm, bus.in_pc};
  assign w_push = bus.in_valid && in_ready_q && !flush;
  assign w_pop  = main_vld_q && bus.out_ready;

  // in_ready is low whenever skid holds data, so push and skid-drain never coincide
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (w_pop) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else if (w_push) begin
          main_d = w_new;
        end else begin
          main_vld_d = 1'b0;
        end
      end else if (w_push) begin
        if (main_vld_q) begin
          skid_d     = w_new;
          skid_vld_d = 1'b1;
        end else begin
          main_d     = w_new;
          main_vld_d = 1'b1;
        end
      end
      if (w_push && (w_op == OP_ILLEGAL) && (cnt_q != '1))
        cnt_d = cnt_q + CNT_W'(1);
    end
    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_vld_q;
  assign bus.out_op    = main_q.op;
  assign bus.out_rd    = main_q.rd;
  assign bus.out_rs1   = main_q.rs1;
  assign bus.out_rs2   = main_q.rs2;
  assign bus.out_imm   = main_q.imm;
  assign bus.out_pc    = main_q.pc;
  assign illegal_cnt   = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decode_stage : directed and random checks of decode_stage against a
// pattern-table decoder and a queue model of the buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage;
  import rv_pkg::*;

  localparam int CNT_MAX  = 65535;
  localparam int CNT2_MAX = 3;

  typedef enum {F_R, F_I, F_S6, F_S5, F_U, F_J} fmt_e;
  typedef struct { logic [31:0] match; op_t op; fmt_e fmt; } pat_t;
  typedef struct { op_t op; logic [4:0] rd, rs1, rs2; logic [63:0] imm, pc; } exp_t;

  logic        clk, rst_n, flush;
  logic [15:0] illegal_cnt;
  logic [1:0]  illegal_cnt2;

  decode_stage_if #(.XLEN(64)) bus ();
  decode_stage_if #(.XLEN(64)) bus2 ();

  decode_stage #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .illegal_cnt(illegal_cnt));
  decode_stage #(.XLEN(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2), .illegal_cnt(illegal_cnt2));

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.in_pc     = bus.in_pc;
  assign bus2.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pat_t pats[$];
  exp_t q[$];
  int   cnt, cnt2;
  bit   rdy_ok;
  int   n_pass, n_fail, n_total;

  function automatic logic [31:0] mask_of(fmt_e f);
    case (f)
      F_R, F_S5: return 32'hFE00707F;
      F_S6:      return 32'hFC00707F;
      F_I:       return 32'h0000707F;
      default:   return 32'h0000007F;
    endcase
  endfunction

  function automatic void add(logic [31:0] m, op_t op, fmt_e f);
    pat_t p;
    p.match = m; p.op = op; p.fmt = f;
    pats.push_back(p);
  endfunction

  function automatic exp_t ref_dec(logic [31:0] w, logic [63:0] pc);
    exp_t e;
    e.op = OP_ILLEGAL; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0; e.pc = pc;
    for (int i = 0; i < pats.size(); i++) begin
      if ((w & mask_of(pats[i].fmt)) == pats[i].match) begin
        e.op = pats[i].op;
        e.rd = w[11:7];
        case (pats[i].fmt)
          F_R:  begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
          F_I:  begin e.rs1 = w[19:15]; e.imm = 64'($signed(w[31:20])); end
          F_S6: begin e.rs1 = w[19:15]; e.imm = 64'(w[25:20]); end
          F_S5: begin e.rs1 = w[19:15]; e.imm = 64'(w[24:20]); end
          F_U:  e.imm = 64'($signed({w[31:12], 12'h000}));
          default: e.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        endcase
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    pat_t p;
    if ($urandom_range(0, 3) == 0) return $urandom();
    p = pats[$urandom_range(0, pats.size() - 1)];
    w = ($urandom() & ~mask_of(p.fmt)) | p.match;
    if ($urandom_range(0, 7) == 0) w[25] = ~w[25];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input op_t op, input int rd, input int rs1,
                         input int rs2, input logic [63:0] imm, input logic [63:0] pc);
    chk({tag, ".valid"}, bus.out_valid, 1'b1);
    chk({tag, ".op"},    bus.out_op,    op);
    chk({tag, ".rd"},    bus.out_rd,    64'(rd));
    chk({tag, ".rs1"},   bus.out_rs1,   64'(rs1));
    chk({tag, ".rs2"},   bus.out_rs2,   64'(rs2));
    chk({tag, ".imm"},   bus.out_imm,   imm);
    chk({tag, ".pc"},    bus.out_pc,    pc);
  endtask

  task automatic check_state();
    chk("model.valid", bus.out_valid, q.size() > 0);
    chk("model.ready", bus.in_ready, rdy_ok && (q.size() < 2));
    chk("model.cnt", illegal_cnt, 64'(cnt));
    chk("model.cnt_sat", illegal_cnt2, 64'(cnt2));
    if (q.size() > 0) begin
      chk("model.op",  bus.out_op,  q[0].op);
      chk("model.rd",  bus.out_rd,  q[0].rd);
      chk("model.rs1", bus.out_rs1, q[0].rs1);
      chk("model.rs2", bus.out_rs2, q[0].rs2);
      chk("model.imm", bus.out_imm, q[0].imm);
      chk("model.pc",  bus.out_pc,  q[0].pc);
    end
  endtask

  // Called at a falling edge: check, drive, advance the model across the next rising edge.
  task automatic cycle(input bit v, input logic [31:0] w, input logic [63:0] pc,
                       input bit ordy, input bit fl);
    bit   acc, pop;
    exp_t e;
    bus.in_valid = v; bus.in_instr = w; bus.in_pc = pc; bus.out_ready = ordy; flush = fl;
    check_state();
    acc = v && rdy_ok && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = ref_dec(w, pc);
        q.push_back(e);
        if (e.op == OP_ILLEGAL) begin
          if (cnt < CNT_MAX) cnt++;
          if (cnt2 < CNT2_MAX) cnt2++;
        end
      end
    end
    rdy_ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    cycle(1'b1, w, pc, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    q.delete(); cnt = 0; cnt2 = 0; rdy_ok = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    add(32'h00000033, OP_ADD, F_R);   add(32'h40000033, OP_SUB, F_R);   add(32'h00004033, OP_XOR, F_R);
    add(32'h00006033, OP_OR, F_R);    add(32'h00007033, OP_AND, F_R);   add(32'h0000003B, OP_ADDW, F_R);
    add(32'h4000003B, OP_SUBW, F_R);  add(32'h02000033, OP_MUL, F_R);   add(32'h02004033, OP_DIV, F_R);
    add(32'h02005033, OP_DIVU, F_R);  add(32'h02006033, OP_REM, F_R);   add(32'h02007033, OP_REMU, F_R);
    add(32'h0200003B, OP_MULW, F_R);  add(32'h0200403B, OP_DIVW, F_R);  add(32'h0200503B, OP_DIVUW, F_R);
    add(32'h0200603B, OP_REMW, F_R);  add(32'h0200703B, OP_REMUW, F_R); add(32'h00000013, OP_ADDI, F_I);
    add(32'h00002013, OP_SLTI, F_I);  add(32'h00004013, OP_XORI, F_I);  add(32'h00006013, OP_ORI, F_I);
    add(32'h00007013, OP_ANDI, F_I);  add(32'h0000001B, OP_ADDIW, F_I); add(32'h00000067, OP_JALR, F_I);
    add(32'h00000037, OP_LUI, F_U);   add(32'h00000017, OP_AUIPC, F_U); add(32'h0000006F, OP_JAL, F_J);
    add(32'h00001013, OP_SLLI, F_S6); add(32'h00005013, OP_SRLI, F_S6); add(32'h40005013, OP_SRAI, F_S6);
    add(32'h0000101B, OP_SLLIW, F_S5); add(32'h0000501B, OP_SRLIW, F_S5); add(32'h4000501B, OP_SRAIW, F_S5);

    rst_n = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.ready", bus.in_ready, 0);
    chk("rst.cnt", illegal_cnt, 0);
    chk("rst.op", bus.out_op, OP_ILLEGAL);
    chk("rst.rd_rs", {bus.out_rd, bus.out_rs1, bus.out_rs2}, 0);
    chk("rst.imm", bus.out_imm, 0);
    chk("rst.pc", bus.out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("release.ready_low", bus.in_ready, 0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("release.ready_high", bus.in_ready, 1);

    send(32'h00500093, 64'h100);
    chk_out("addi", OP_ADDI, 1, 0, 0, 64'd5, 64'h100);
    send(32'h002081B3, 64'h104);
    chk_out("add", OP_ADD, 3, 1, 2, 64'd0, 64'h104);
    send(32'h02208233, 64'h108);
    chk_out("mul", OP_MUL, 4, 1, 2, 64'd0, 64'h108);
    send(32'h123452B7, 64'h10C);
    chk_out("lui", OP_LUI, 5, 0, 0, 64'h12345000, 64'h10C);
    send(32'hFFDFF0EF, 64'h110);
    chk_out("jal", OP_JAL, 1, 0, 0, 64'hFFFFFFFFFFFFFFFC, 64'h110);
    chk("cnt_before_illegal", illegal_cnt, 0);
    send(32'hFFFFFFFF, 64'h114);
    chk_out("illegal", OP_ILLEGAL, 0, 0, 0, 64'd0, 64'h114);
    chk("cnt_after_illegal", illegal_cnt, 1);
    send(32'h0210909B, 64'h118);
    chk("slliw_bit25.op", bus.out_op, OP_ILLEGAL);
    chk("slliw_bit25.cnt", illegal_cnt, 2);
    send(32'h4050D093, 64'h11C);
    chk_out("srai", OP_SRAI, 1, 1, 0, 64'd5, 64'h11C);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Backpressure: third word must be refused while both entries are held
    cycle(1'b1, 32'h00500093, 64'h1000, 1'b0, 1'b0);
    cycle(1'b1, 32'h002081B3, 64'h2000, 1'b0, 1'b0);
    chk("bp.ready_low", bus.in_ready, 0);
    chk_out("bp.head", OP_ADDI, 1, 0, 0, 64'd5, 64'h1000);
    cycle(1'b1, 32'h02208233, 64'h3000, 1'b0, 1'b0);
    chk_out("bp.stable", OP_ADDI, 1, 0, 0, 64'd5, 64'h1000);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk_out("bp.second", OP_ADD, 3, 1, 2, 64'd0, 64'h2000);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("bp.drained", bus.out_valid, 0);

    cycle(1'b1, 32'h00500093, 64'h4000, 1'b0, 1'b0);
    cycle(1'b1, 32'h002081B3, 64'h4004, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFFFFFF, 64'h4008, 1'b0, 1'b1);
    chk("flush_full.valid", bus.out_valid, 0);
    chk("flush_full.ready", bus.in_ready, 1);
    chk("flush_full.cnt", illegal_cnt, 2);
    cycle(1'b1, 32'h00500093, 64'h5000, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFFFFFF, 64'h5004, 1'b0, 1'b1);
    chk("flush_hs.valid", bus.out_valid, 0);
    chk("flush_hs.cnt", illegal_cnt, 2);

    cycle(1'b1, 32'h00500093, 64'h6000, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFFFFFF, 64'h6004, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst.valid", bus.out_valid, 0);
    chk("midrst.ready", bus.in_ready, 0);
    chk("midrst.cnt", illegal_cnt, 0);
    chk("midrst.op", bus.out_op, OP_ILLEGAL);
    chk("midrst.pc", bus.out_pc, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_word(), {$urandom(), $urandom()},
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, default 64, operand and immediate width.
REQ-002 Parameter: CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 Port: clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: flush, input, 1, synchronous discard of all buffered entries.
REQ-006 Port: in_valid / in_ready, input / output, 1 / 1, handshake for the fetched instruction.
REQ-007 Port: in_instr, input, 32, raw RV64 instruction word.
REQ-008 Port: in_pc, input, XLEN, address of in_instr.
REQ-009 Port: out_valid / out_ready, output / input, 1 / 1, handshake toward the executer.
REQ-010 Port: out_op, output, op_t, decoded operation.
REQ-011 Port: out_rd / out_rs1 / out_rs2, output, 5 each, register indices.
REQ-012 Port: out_imm, output, XLEN, sign-extended immediate.
REQ-013 Port: out_pc, output, XLEN, pc carried with the instruction.
REQ-014 Port: illegal_cnt, output, CNT_W, count of instructions decoded as OP_ILLEGAL.

Function
REQ-015 A transfer SHALL occur on a cycle where valid and ready are both high; in and out sides are independent.
REQ-016 Latency SHALL be 1 cycle: a word accepted in cycle N is presentable on out_* in cycle N+1.
REQ-017 Storage SHALL be a 2-entry skid buffer (main, skid); in_ready SHALL be a registered signal, high when the skid entry is empty, with no combinational path from out_ready.
REQ-018 Output SHALL be FIFO order; out_* SHALL be held stable while out_valid && !out_ready.
REQ-019 Simultaneous push and pop with one entry held SHALL leave occupancy at 1 with the new entry in main.
REQ-020 When both entries are full, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-021 Decode SHALL cover: ADD, ADDW, SUB, SUBW, XOR, OR, AND, ADDI, ADDIW, SLTI, ANDI, XORI, ORI, LUI, AUIPC, JAL, JALR, SLLI, SRLI, SRAI, SLLIW, SRLIW, SRAIW, MUL, MULW, DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW; any other encoding SHALL yield OP_ILLEGAL.
REQ-022 Immediate rules SHALL be:
- I-type: instr[31:20] sign-extended.
- U-type: {instr[31:12], 12'b0} sign-extended.
- J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} sign-extended.
- Shifts: shamt zero-extended (6 bits RV64, 5 bits W-forms).
- R-type: 0.
REQ-023 Shift checks SHALL be:
- SRAI/SRAIW require funct6/funct7 = 0b0100000.
- W-form shifts with instr[25]=1 SHALL be OP_ILLEGAL.
REQ-024 Fields not defined by the format SHALL be output as 0.
REQ-025 illegal_cnt SHALL increment by 1 on each accepted in_* transfer that decodes as OP_ILLEGAL and SHALL saturate at all-ones.
REQ-026 flush SHALL empty both entries next cycle (out_valid=0, in_ready=1); an input handshake in the flush cycle SHALL be discarded and not counted.

Reset
REQ-027 While rst_n=0, the following SHALL hold asynchronously:
- out_valid=0, in_ready=0, illegal_cnt=0, both entries empty.
- out_op=OP_ILLEGAL; out_rd, out_rs1, out_rs2, out_imm and out_pc = 0.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts; reset mid-transfer SHALL drop all buffered entries.

Structure
REQ-029 Package rv_pkg SHALL hold op_t, the opcode/funct3/funct7 constants and XLEN.
REQ-030 Pure combinational decode SHALL be a sub-module rv_decode_comb (instr in, op/rd/rs1/rs2/imm out), instantiated once ahead of the skid buffer.

Verification
REQ-031 0x00500093 at pc 0x100 SHALL give: OP_ADDI, rd=1, rs1=0, imm=5, pc=0x100, one cycle later.
REQ-032 0x002081B3 SHALL give OP_ADD, rd=3, rs1=1, rs2=2, imm=0; 0x02208233 SHALL give OP_MUL, rd=4.
REQ-033 0x123452B7 SHALL give OP_LUI, rd=5, imm=0x12345000; 0xFFDFF0EF SHALL give OP_JAL, rd=1, imm=0xFFFFFFFFFFFFFFFC.
REQ-034 0xFFFFFFFF SHALL give OP_ILLEGAL and illegal_cnt 0 -> 1; an SLLIW with instr[25]=1 SHALL also give OP_ILLEGAL.
REQ-035 Backpressure test:
- Stimulus: out_ready=0 while three words are offered.
- Response: two accepted, in_ready=0 on the third; out_* stable.
- Then out_ready=1: words SHALL emerge in order with no loss or duplication.
REQ-036 flush with two entries held and in_valid=1 SHALL give out_valid=0 next cycle, in_ready=1, and illegal_cnt unchanged.
